// File: rtl/comb_scan_ctrl.sv
// comb_scan_ctrl: self-test sequencer for the 5-input selector block.
// Walks the 32 input vectors in order and holds each one for SETTLE+1 cycles.
// Y is sampled in the last cycle of each slot to build the captured truth table.
// The captured table is compared against a copy of exp_tt latched at start.
module comb_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] exp_tt,
  input  logic        y,
  output logic        sel,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [31:0] tt,
  output logic [5:0]  err_cnt,
  output logic        first_err_vld,
  output logic [4:0]  first_err_idx,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, SETL, SAMP, DON} state_t;

  localparam logic [3:0] SET_L = 4'(SETTLE);

  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] exp_reg;
  logic        clr, smp_we, fin, abt;
  logic        mis;

  // The vector index drives the block directly: {sel,a,b,c,d} = idx.
  assign {sel, a, b, c, d} = idx;
  assign busy = (state == SETL) || (state == SAMP);
  assign done = (state == DON);
  assign mis  = y ^ exp_reg[idx];

  // State, vector index and settle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; abort takes priority over sampling in the scan states.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    clr      = 1'b0;
    smp_we   = 1'b0;
    fin      = 1'b0;
    abt      = 1'b0;
    case (state)
      IDLE: begin
        idx_nx = '0;
        if (start) begin
          clr      = 1'b1;
          cnt_nx   = SET_L;
          state_nx = (SETTLE == 0) ? SAMP : SETL;
        end
      end
      SETL: begin
        if (abort) begin
          abt      = 1'b1;
          idx_nx   = '0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt <= 4'd1) state_nx = SAMP;
        end
      end
      SAMP: begin
        if (abort) begin
          abt      = 1'b1;
          idx_nx   = '0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          smp_we = 1'b1;
          if (idx == 5'd31) begin
            state_nx = DON;
          end else begin
            idx_nx   = idx + 5'd1;
            cnt_nx   = SET_L;
            state_nx = (SETTLE == 0) ? SAMP : SETL;
          end
        end
      end
      DON: begin
        fin      = 1'b1;
        idx_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        idx_nx   = '0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Capture, compare and result registers; results hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_reg       <= '0;
      tt            <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      pass          <= 1'b0;
    end else if (clr) begin
      exp_reg       <= exp_tt;
      tt            <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      pass          <= 1'b0;
    end else if (smp_we) begin
      tt[idx] <= y;
      if (mis) begin
        err_cnt <= err_cnt + 6'd1;
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= idx;
        end
      end
    end else if (fin) begin
      pass <= (err_cnt == 6'd0);
    end else if (abt) begin
      pass <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comb_scan_ctrl.sv
// tb_comb_scan_ctrl: drives two controllers (SETTLE=2 and SETTLE=0) with a
// stub selector block and checks the vector walk, timing and scan results.
module tb_comb_scan_ctrl;

  typedef struct {
    int          u;
    int          mode;
    logic [31:0] tbl;
    logic [31:0] exp;
    bit          poke;
    int          abort_at;
    logic [31:0] e_tt;
    int          e_err;
    bit          e_fev;
    int          e_fei;
    bit          e_pass;
  } case_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v[2];
  logic        abort_v[2];
  logic        y_v[2];
  logic [31:0] exp_v[2];
  wire         busy_w[2];
  wire         done_w[2];
  wire         fev_w[2];
  wire         pass_w[2];
  wire  [31:0] tt_w[2];
  wire  [5:0]  err_w[2];
  wire  [4:0]  fei_w[2];
  wire  [4:0]  vec0, vec1;
  wire  [4:0]  vec_w[2];

  int checks = 0;
  int errors = 0;

  assign vec_w[0] = vec0;
  assign vec_w[1] = vec1;

  always #5 clk = ~clk;

  comb_scan_ctrl #(.SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .exp_tt(exp_v[0]), .y(y_v[0]),
    .sel(vec0[4]), .a(vec0[3]), .b(vec0[2]), .c(vec0[1]), .d(vec0[0]),
    .busy(busy_w[0]), .done(done_w[0]), .tt(tt_w[0]), .err_cnt(err_w[0]),
    .first_err_vld(fev_w[0]), .first_err_idx(fei_w[0]), .pass(pass_w[0])
  );

  comb_scan_ctrl #(.SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .exp_tt(exp_v[1]), .y(y_v[1]),
    .sel(vec1[4]), .a(vec1[3]), .b(vec1[2]), .c(vec1[1]), .d(vec1[0]),
    .busy(busy_w[1]), .done(done_w[1]), .tt(tt_w[1]), .err_cnt(err_w[1]),
    .first_err_vld(fev_w[1]), .first_err_idx(fei_w[1]), .pass(pass_w[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t", nm, act, want, $time);
    end
  endtask

  function automatic int settle_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Ideal response of the stub block for vector v.
  function automatic logic ideal(input int mode, input int v, input logic [31:0] tbl);
    logic [4:0] vv;
    vv = 5'(v);
    case (mode)
      0:       return vv[0];
      1:       return 1'b1;
      2:       return vv[0] ^ (v == 19);
      default: return tbl[v];
    endcase
  endfunction

  // Mode 4 drives the wrong value in every slot cycle except the last one.
  function automatic logic stub(input int mode, input int v, input int ph, input int s,
                                input logic [31:0] tbl);
    return ideal(mode, v, tbl) ^ ((mode == 4) && (ph != s));
  endfunction

  // Reference: which vectors get sampled, what lands in tt, and the error summary.
  function automatic case_t model(input case_t c);
    case_t r;
    int slot, nsmp;
    r = c;
    slot = settle_of(c.u) + 1;
    nsmp = 0;
    for (int v = 0; v < 32; v++)
      if (c.abort_at == 0 || (v + 1) * slot < c.abort_at) nsmp++;
    r.e_tt = '0; r.e_err = 0; r.e_fev = 0; r.e_fei = 0;
    for (int v = 0; v < nsmp; v++) begin
      r.e_tt[v] = ideal(c.mode, v, c.tbl);
      if (r.e_tt[v] != c.exp[v]) begin
        if (!r.e_fev) r.e_fei = v;
        r.e_fev = 1;
        r.e_err++;
      end
    end
    r.e_pass = (c.abort_at == 0) && (r.e_err == 0);
    return r;
  endfunction

  // One scan on instance c.u, checking the vector walk cycle by cycle.
  task automatic run_case(input case_t c, input string nm);
    int s, slot, total, u;
    bit aborted;
    u = c.u; s = settle_of(u); slot = s + 1; total = 32 * slot;
    aborted = 0;
    @(negedge clk);
    exp_v[u] = c.exp; start_v[u] = 1'b1; abort_v[u] = 1'b0;
    @(negedge clk);
    start_v[u] = 1'b0;
    exp_v[u] = ~c.exp;
    for (int k = 1; k <= total; k++) begin
      chk({nm, " vec"}, 32'(vec_w[u]), 32'((k - 1) / slot));
      chk({nm, " busy"}, 32'(busy_w[u]), 32'd1);
      chk({nm, " done_early"}, 32'(done_w[u]), 32'd0);
      y_v[u] = stub(c.mode, int'(vec_w[u]), (k - 1) % slot, s, c.tbl);
      start_v[u] = c.poke && (k % 7 == 3);
      if (k == c.abort_at) begin
        abort_v[u] = 1'b1;
        @(negedge clk);
        abort_v[u] = 1'b0; start_v[u] = 1'b0;
        chk({nm, " abort_busy"}, 32'(busy_w[u]), 32'd0);
        chk({nm, " abort_vec"}, 32'(vec_w[u]), 32'd0);
        aborted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!aborted) begin
      start_v[u] = c.poke;
      chk({nm, " done"}, 32'(done_w[u]), 32'd1);
      chk({nm, " done_busy"}, 32'(busy_w[u]), 32'd0);
      @(negedge clk);
      start_v[u] = 1'b0;
      chk({nm, " done_pulse"}, 32'(done_w[u]), 32'd0);
      chk({nm, " idle_busy"}, 32'(busy_w[u]), 32'd0);
      chk({nm, " idle_vec"}, 32'(vec_w[u]), 32'd0);
    end
    repeat (3) begin
      @(negedge clk);
      chk({nm, " no_done"}, 32'(done_w[u]), 32'd0);
    end
    y_v[u] = 1'b0;
    chk({nm, " tt"}, tt_w[u], c.e_tt);
    chk({nm, " err_cnt"}, 32'(err_w[u]), 32'(c.e_err));
    chk({nm, " first_err_vld"}, 32'(fev_w[u]), 32'(c.e_fev));
    chk({nm, " first_err_idx"}, 32'(fei_w[u]), 32'(c.e_fei));
    chk({nm, " pass"}, 32'(pass_w[u]), 32'(c.e_pass));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    case_t tab[9];
    case_t rc;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 0; abort_v[u] = 0; y_v[u] = 0; exp_v[u] = '0;
    end
    // u mode tbl exp poke abort | tt err fev fei pass
    tab[0] = '{0, 0, 32'h0, 32'hAAAAAAAA, 1, 0,  32'hAAAAAAAA, 0,  1'b0, 0,  1'b1};
    tab[1] = '{0, 1, 32'h0, 32'h00000000, 0, 0,  32'hFFFFFFFF, 32, 1'b1, 0,  1'b0};
    tab[2] = '{0, 2, 32'h0, 32'hAAAAAAAA, 0, 0,  32'hAAA2AAAA, 1,  1'b1, 19, 1'b0};
    tab[3] = '{1, 0, 32'h0, 32'hAAAAAAAA, 1, 0,  32'hAAAAAAAA, 0,  1'b0, 0,  1'b1};
    tab[4] = '{0, 4, 32'h3C5A9613, 32'h3C5A9613, 0, 0, 32'h3C5A9613, 0, 1'b0, 0, 1'b1};
    tab[5] = '{1, 2, 32'h0, 32'hAAAAAAAA, 0, 0,  32'hAAA2AAAA, 1,  1'b1, 19, 1'b0};
    tab[6] = '{0, 1, 32'h0, 32'h00000000, 1, 40, 32'h00001FFF, 13, 1'b1, 0,  1'b0};
    tab[7] = '{0, 0, 32'h0, 32'hAAAAAAAA, 1, 0,  32'hAAAAAAAA, 0,  1'b0, 0,  1'b1};
    tab[8] = '{0, 0, 32'h0, 32'hAAAAAAAA, 1, 40, 32'h00000AAA, 0,  1'b0, 0,  1'b0};

    // Reset state.
    rst_n = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      chk("rst busy", 32'(busy_w[u]), 32'd0);
      chk("rst done", 32'(done_w[u]), 32'd0);
      chk("rst vec", 32'(vec_w[u]), 32'd0);
      chk("rst tt", tt_w[u], 32'd0);
      chk("rst err_cnt", 32'(err_w[u]), 32'd0);
      chk("rst fev", 32'(fev_w[u]), 32'd0);
      chk("rst fei", 32'(fei_w[u]), 32'd0);
      chk("rst pass", 32'(pass_w[u]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven scans.
    for (int i = 0; i < 9; i++) run_case(tab[i], $sformatf("tab%0d", i));

    // Asynchronous reset in the settle part of vector 10.
    @(negedge clk);
    exp_v[0] = 32'h0; start_v[0] = 1'b1; y_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("arst pre_vec", 32'(vec0), 32'd10);
    chk("arst pre_err", 32'(err_w[0]), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy_w[0]), 32'd0);
    chk("arst vec", 32'(vec0), 32'd0);
    chk("arst tt", tt_w[0], 32'd0);
    chk("arst err_cnt", 32'(err_w[0]), 32'd0);
    chk("arst fev", 32'(fev_w[0]), 32'd0);
    #1 rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (80) begin
        @(negedge clk);
        if (done_w[0] || busy_w[0]) seen++;
      end
      chk("arst quiet", 32'(seen), 32'd0);
    end
    y_v[0] = 1'b0;
    run_case(tab[0], "arst rescan");

    // Randomized scans against the reference model.
    for (int i = 0; i < 10; i++) begin
      int total;
      rc.u        = int'($urandom_range(0, 1));
      rc.mode     = int'($urandom_range(3, 4));
      rc.tbl      = $urandom;
      rc.exp      = rc.tbl ^ ($urandom & $urandom & $urandom);
      rc.poke     = 1'($urandom_range(0, 1));
      total       = 32 * (settle_of(rc.u) + 1);
      rc.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
      rc = model(rc);
      run_case(rc, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comb_scan_ctrl.md
Name: comb_scan_ctrl

Overview:
Sequencing controller for the 5-input combinational selector block (inputs sel, A, B, C, D; output Y). On start it walks all 32 input vectors in order and holds each one for a programmable settle time. It samples Y for every vector, builds the captured 32-entry truth table, and compares it against an expected table. It sits beside the combinational block as its on-chip self-test and characterisation sequencer, replacing free-running bench stimulus.

Parameters:
SETTLE, 2, extra cycles each vector is held before Y is sampled; legal range 0..15; each vector slot lasts SETTLE+1 cycles.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  begin scan; sampled only in IDLE
abort  input  1  synchronous scan cancel; ignored in IDLE
exp_tt  input  32  expected truth table; bit i = expected Y for vector i; captured at start
y  input  1  Y from the combinational block
sel  output  1  drive to block; equals idx[4]
a  output  1  equals idx[3]
b  output  1  equals idx[2]
c  output  1  equals idx[1]
d  output  1  equals idx[0]
busy  output  1  high while scanning
done  output  1  one-cycle pulse after a completed scan
tt  output  32  captured truth table; bit i = sampled Y for vector i
err_cnt  output  6  number of mismatching vectors, 0..32
first_err_vld  output  1  at least one mismatch seen in the current or last scan
first_err_idx  output  5  index of the lowest mismatching vector; 0 when first_err_vld=0
pass  output  1  last completed scan had err_cnt==0

Behaviour:
- Reset: rst_n low clears all state immediately, regardless of clk.
  - FSM goes to IDLE; idx=0, so sel/a/b/c/d=0.
  - busy, done, pass, first_err_vld = 0; tt=0; err_cnt=0; first_err_idx=0; settle counter=0.
- Reset asserted mid-scan: same as above. No done pulse. Results are lost.
- Vector outputs are registered and are always {sel,a,b,c,d} = idx.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Outputs idx=0.
  - On start=1 at a clock edge: latch exp_tt into an internal register.
  - Clear tt, err_cnt, first_err_vld, first_err_idx and pass.
  - Set idx=0, cnt=SETTLE, busy=1.
  - Go to SAMPLE if SETTLE==0, else go to SETTLE.
- SETTLE: cnt decrements by 1 each cycle. When cnt reaches 1, the next state is SAMPLE.
- SAMPLE: lasts one cycle. At its closing edge:
  - tt[idx] <= y.
  - If y != exp_reg[idx]: err_cnt increments. If first_err_vld==0, set first_err_idx=idx and first_err_vld=1.
  - If idx==31: go to DONE.
  - Otherwise: idx increments, cnt reloads to SETTLE, and the next state is SETTLE (or SAMPLE if SETTLE==0).
- Slot timing: each vector is stable for exactly SETTLE+1 cycles. The first vector-0 cycle is the cycle after the start edge.
- Full scan: 32*(SETTLE+1) cycles; 96 cycles for the default SETTLE=2.
- DONE: lasts one cycle.
  - done=1 and busy=0 in this cycle.
  - pass <= (err_cnt==0), using the final count.
  - idx returns to 0; next state IDLE.
- Outputs tt, err_cnt, first_err_* and pass hold after DONE until the next accepted start.
- start while busy or in DONE: ignored. No restart, no queueing.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE; idx=0; busy=0.
  - No done pulse; pass=0.
  - tt, err_cnt and first_err_* keep their partial values. A sample in the abort cycle is not written.
- abort has priority over sampling. abort and start together in IDLE: start wins (abort is ignored in IDLE).
- exp_tt changes during a scan have no effect, because the latched copy is used.
- err_cnt is 6 bits and cannot overflow, since its maximum value is 32.

Test Plan:
- Async reset: pulse rst_n low during SETTLE of vector 10 (not on a clock edge). Required: busy/sel..d/tt/err_cnt go to 0 immediately; no done; a later start scans from vector 0.
- Bench stub y=d, exp_tt=32'hAAAAAAAA, SETTLE=2. Required: done pulses 97 cycles after the start edge (96 cycles busy); tt=32'hAAAAAAAA; err_cnt=0; pass=1; first_err_vld=0.
- Stub y stuck at 1, exp_tt=32'h00000000. Required: tt=32'hFFFFFFFF; err_cnt=32; first_err_vld=1; first_err_idx=0; pass=0.
- Stub y=d except inverted at vector 19, exp_tt=32'hAAAAAAAA. Required: err_cnt=1; first_err_idx=19; tt=32'hAAA2AAAA; pass=0.
- Timing checks:
  - Instance with SETTLE=0: every vector held exactly 1 cycle; busy exactly 32 cycles.
  - SETTLE=2: {sel..d} advances every 3 cycles; y sampled at the final edge of each slot, checked with a bench stub that toggles y mid-slot.
- Start asserted during the scan is ignored. abort in cycle 40 of the scan (vector 13): busy drops next cycle; no done; pass=0; tt bits 0..12 are valid. A new start then completes with pass=1.
